// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU sequencer/arbiter and its neighbours:
//   - FPU datapath widths (operand/result width, command width)
//   - FPU command code constants (passed through unmodified by the arbiter)
//   - fpu_arbiter state encoding
// No ports; this is a package.
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int FPU_WIDTH = 32;
    localparam int FPU_CMD_W = 4;

    localparam logic [FPU_CMD_W-1:0] FPU_CMD_ADD     = 4'd0;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_SUB     = 4'd1;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_MUL     = 4'd2;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_DIV     = 4'd3;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_SQRT    = 4'd4;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_ABS     = 4'd5;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_NEG     = 4'd6;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_CMP     = 4'd7;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_CVT_W_S = 4'd8;
    localparam logic [FPU_CMD_W-1:0] FPU_CMD_CVT_S_W = 4'd9;

    typedef enum logic [1:0] {
        FA_IDLE = 2'd0,
        FA_EXEC = 2'd1,
        FA_RESP = 2'd2
    } fa_state_e;

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin priority picker. The search starts at the
// requester just above last_grant and wraps modulo N; the first set request
// bit found wins.
// Ports:
//   req        in  N     request vector
//   last_grant in  IDXW  index of the most recently served requester
//   grant      out N     one-hot grant (all zero when req is all zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N    = 2,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last_grant,
    output logic [N-1:0]    grant
);

    logic [IDXW-1:0] w_idx;
    logic            w_found;
    logic            w_hit;

    // Rotating priority search; w_found masks every candidate after the first hit.
    always_comb begin
        grant   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_hit   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            w_idx        = IDXW'((int'(last_grant) + i) % N);
            w_hit        = req[w_idx] & ~w_found;
            grant[w_idx] = grant[w_idx] | w_hit;
            w_found      = w_found | w_hit;
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
// Shares one external combinational FPU between NUM_REQ requesters. A granted
// request's operands are latched and driven to the FPU for SETTLE cycles, the
// FPU result is then captured and returned on the owner's response channel.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake (ready one-hot)
//   req_a/req_b/req_cmd        packed per-requester operands and command
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_result                 captured FPU result
//   fpu_a/fpu_b/fpu_cmd        registered FPU inputs
//   fpu_result                 FPU output
//   busy                       high while in EXEC or RESP
// -----------------------------------------------------------------------------
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SETTLE  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [FPU_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [FPU_WIDTH*NUM_REQ-1:0] req_b,
    input  logic [FPU_CMD_W*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [FPU_WIDTH-1:0]         rsp_result,
    output logic [FPU_WIDTH-1:0]         fpu_a,
    output logic [FPU_WIDTH-1:0]         fpu_b,
    output logic [FPU_CMD_W-1:0]         fpu_cmd,
    input  logic [FPU_WIDTH-1:0]         fpu_result,
    output logic                         busy
);

    localparam int IDXW = $clog2(NUM_REQ);
    // Counter only ever holds SETTLE-1 .. 0.
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0]    CNT_LOAD  = CNTW'(SETTLE - 1);
    localparam logic [IDXW-1:0]    LAST_INIT = IDXW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_OH    = {{(NUM_REQ-1){1'b0}}, 1'b1};

    fa_state_e             r_state;
    fa_state_e             w_state_nxt;
    logic [IDXW-1:0]       r_last_grant;
    logic [IDXW-1:0]       r_owner;
    logic [IDXW-1:0]       w_grant_idx;
    logic [CNTW-1:0]       r_cnt;
    logic [FPU_WIDTH-1:0]  r_a;
    logic [FPU_WIDTH-1:0]  r_b;
    logic [FPU_CMD_W-1:0]  r_cmd;
    logic [FPU_WIDTH-1:0]  r_result;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [NUM_REQ-1:0]    w_rsp_valid_nxt;
    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_owner_oh;
    logic                  r_busy;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_accept;

    logic [FPU_WIDTH-1:0]  w_a_arr   [NUM_REQ];
    logic [FPU_WIDTH-1:0]  w_b_arr   [NUM_REQ];
    logic [FPU_CMD_W-1:0]  w_cmd_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_a_arr[g]   = req_a[FPU_WIDTH*g +: FPU_WIDTH];
        assign w_b_arr[g]   = req_b[FPU_WIDTH*g +: FPU_WIDTH];
        assign w_cmd_arr[g] = req_cmd[FPU_CMD_W*g +: FPU_CMD_W];
    end

    rr_arbiter #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Encode the one-hot grant as an index for operand selection and ownership.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_idx = w_grant_idx | (IDXW'(i) & {IDXW{w_grant[i]}});
        end
    end

    // Ready is combinational in IDLE and forced low while reset is asserted.
    assign req_ready  = ((r_state == FA_IDLE) && reset) ? w_grant : '0;
    assign w_owner_oh = ONE_OH << r_owner;

    // Next-state logic and datapath enables.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            FA_IDLE: begin
                if (|(req_valid & req_ready)) begin
                    w_state_nxt = FA_EXEC;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = FA_IDLE;
                end
            end
            FA_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = FA_RESP;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = FA_EXEC;
                end
            end
            FA_RESP: begin
                // Only the owner's rsp_ready can retire the response.
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = FA_IDLE;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = FA_RESP;
                end
            end
            default: begin
                w_state_nxt = FA_IDLE;
            end
        endcase
    end

    // Next value of the registered response-valid vector.
    always_comb begin
        if (w_capture) begin
            w_rsp_valid_nxt = w_owner_oh;
        end else if (w_accept) begin
            w_rsp_valid_nxt = '0;
        end else begin
            w_rsp_valid_nxt = r_rsp_valid;
        end
    end

    // State register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FA_IDLE;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_busy      <= (w_state_nxt != FA_IDLE);
        end
    end

    // Operand latch, settle counter, result capture and round-robin history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_cmd        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_last_grant <= LAST_INIT;
        end else begin
            if (w_load) begin
                r_a     <= w_a_arr[w_grant_idx];
                r_b     <= w_b_arr[w_grant_idx];
                r_cmd   <= w_cmd_arr[w_grant_idx];
                r_owner <= w_grant_idx;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == FA_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
            if (w_capture) begin
                r_result <= fpu_result;
            end
            if (w_accept) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign fpu_a      = r_a;
    assign fpu_b      = r_b;
    assign fpu_cmd    = r_cmd;
    assign rsp_result = r_result;
    assign rsp_valid  = r_rsp_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter
// Directed bench for fpu_arbiter. u_dut uses SETTLE=2, u_dut1 uses SETTLE=1.
// The FPU beside each arbiter is a behavioural stand-in: it returns exact
// single-precision sums for the directed ADD vectors and a fixed mixing
// function of a, b and cmd otherwise.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SETTLE=2 instance
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_cmd;
    logic [31:0] rsp_result, fpu_a, fpu_b, fpu_result;
    logic [3:0]  fpu_cmd;
    logic        busy;

    // SETTLE=1 instance
    logic [1:0]  s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [63:0] s_req_a, s_req_b;
    logic [7:0]  s_req_cmd;
    logic [31:0] s_rsp_result, s_fpu_a, s_fpu_b, s_fpu_result;
    logic [3:0]  s_fpu_cmd;
    logic        s_busy;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] cmd);
        if (cmd == FPU_CMD_ADD && b == 32'h0000_0000) return a;
        if (cmd == FPU_CMD_ADD && a == b) return a + 32'h0080_0000;
        if (cmd == FPU_CMD_ADD && a == 32'h40C8_F5C3 && b == 32'h4048_F5C3) return 32'h4116_B852;
        return (a ^ {b[15:0], b[31:16]}) + {28'd0, cmd};
    endfunction

    assign fpu_result   = fpu_model(fpu_a, fpu_b, fpu_cmd);
    assign s_fpu_result = fpu_model(s_fpu_a, s_fpu_b, s_fpu_cmd);

    fpu_arbiter #(.NUM_REQ(2), .SETTLE(2)) u_dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_cmd(fpu_cmd), .fpu_result(fpu_result),
        .busy(busy)
    );

    fpu_arbiter #(.NUM_REQ(2), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b), .req_cmd(s_req_cmd),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_result(s_rsp_result),
        .fpu_a(s_fpu_a), .fpu_b(s_fpu_b), .fpu_cmd(s_fpu_cmd), .fpu_result(s_fpu_result),
        .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] a1, b1;
    logic [3:0]  c1;
    logic [1:0]  exp_oh;
    int          r, waited, prev_cyc;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 2'b11;
        req_a       = 64'd0;
        req_b       = 64'd0;
        req_cmd     = 8'd0;
        rsp_ready   = 2'b00;
        s_req_valid = 2'b00;
        s_req_a     = 64'd0;
        s_req_b     = 64'd0;
        s_req_cmd   = 8'd0;
        s_rsp_ready = 2'b00;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(req_ready), 32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_fpu_a",      fpu_a, 32'd0);
        chk("rst_fpu_b",      fpu_b, 32'd0);
        chk("rst_fpu_cmd",    32'(fpu_cmd), 32'd0);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst1_busy",      32'(s_busy), 32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", 32'(req_ready), 32'd0);

        // ---------------- req0 only, latency and hold ----------------
        req_a[31:0]  = 32'h4048_F5C3;
        req_b[31:0]  = 32'h0000_0000;
        req_cmd[3:0] = FPU_CMD_ADD;
        req_valid    = 2'b01;
        #1 chk("t1_grant0", 32'(req_ready), 32'd1);
        @(negedge clk);                      // cycle T+1 (EXEC)
        req_valid = 2'b00;
        req_a     = 64'hDEAD_BEEF_1234_5678; // operands only matter in handshake cycle
        req_b     = 64'hCAFE_F00D_8765_4321;
        chk("t1_busy_exec", 32'(busy), 32'd1);
        chk("t1_fpu_a",     fpu_a, 32'h4048_F5C3);
        chk("t1_fpu_b",     fpu_b, 32'h0000_0000);
        chk("t1_rv_t1",     32'(rsp_valid), 32'd0);
        @(negedge clk);                      // cycle T+2
        chk("t1_rv_t2",     32'(rsp_valid), 32'd0);
        @(negedge clk);                      // cycle T+3
        chk("t1_rv_t3",     32'(rsp_valid), 32'd1);
        chk("t1_result",    rsp_result, 32'h4048_F5C3);
        req_valid = 2'b11;                   // must not be accepted in RESP
        rsp_ready = 2'b10;                   // non-owner ready is ignored
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result",    rsp_result, 32'h4048_F5C3);
            chk("hold_busy",      32'(busy), 32'd1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        @(negedge clk);                      // accepted; now IDLE
        rsp_ready = 2'b00;
        chk("t1_rv_cleared", 32'(rsp_valid), 32'd0);
        chk("t1_idle_busy",  32'(busy), 32'd0);
        chk("t1_fpu_a_hold", fpu_a, 32'h4048_F5C3);

        // ---------------- round robin after req0, then reset mid-EXEC ----------------
        req_a[63:32]  = 32'h3F80_0000;
        req_b[63:32]  = 32'h3F80_0000;
        req_cmd[7:4]  = FPU_CMD_MUL;
        req_valid     = 2'b11;
        #1 chk("rr_grant1", 32'(req_ready), 32'd2);
        @(negedge clk);                      // EXEC cycle 1
        req_valid = 2'b00;
        chk("c_fpu_a",   fpu_a, 32'h3F80_0000);
        chk("c_fpu_cmd", 32'(fpu_cmd), 32'(FPU_CMD_MUL));
        @(negedge clk);                      // EXEC cycle 2
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready",  32'(req_ready), 32'd0);
        chk("mrst_rsp_valid",  32'(rsp_valid), 32'd0);
        chk("mrst_rsp_result", rsp_result, 32'd0);
        chk("mrst_fpu_a",      fpu_a, 32'd0);
        chk("mrst_fpu_b",      fpu_b, 32'd0);
        chk("mrst_fpu_cmd",    32'(fpu_cmd), 32'd0);
        chk("mrst_busy",       32'(busy), 32'd0);
        req_a[31:0]  = 32'h4048_F5C3;
        req_b[31:0]  = 32'h4048_F5C3;
        req_cmd[3:0] = FPU_CMD_ADD;
        req_a[63:32] = 32'h40C8_F5C3;
        req_b[63:32] = 32'h4048_F5C3;
        req_cmd[7:4] = FPU_CMD_ADD;
        req_valid    = 2'b11;
        rsp_ready    = 2'b11;
        @(negedge clk);
        chk("mrst_ready_low_valid", 32'(req_ready), 32'd0);
        chk("mrst_no_rsp",          32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_grant0", 32'(req_ready), 32'd1);

        // ---------------- 6 back-to-back ops, alternating grants ----------------
        prev_cyc = 0;
        for (int op = 0; op < 6; op++) begin
            waited = 0;
            while (rsp_valid == 2'b00 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("rr_owner",  32'(rsp_valid), (op % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_result", rsp_result, (op % 2 == 0) ? 32'h40C8_F5C3 : 32'h4116_B852);
            if (op > 0) chk("rr_period", 32'(cyc - prev_cyc), 32'd4);
            prev_cyc = cyc;
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1 chk("rr_end_busy", 32'(busy), 32'd0);

        // ---------------- SETTLE=1, random operands ----------------
        for (int op = 0; op < 6; op++) begin
            a1 = $urandom;
            b1 = $urandom;
            c1 = 4'($urandom_range(0, 15));
            r  = op % 2;
            exp_oh = (r == 0) ? 2'b01 : 2'b10;
            s_req_a = {$urandom, $urandom};
            s_req_b = {$urandom, $urandom};
            s_req_cmd = 8'($urandom);
            s_req_a[32*r +: 32] = a1;
            s_req_b[32*r +: 32] = b1;
            s_req_cmd[4*r +: 4] = c1;
            s_req_valid = exp_oh;
            #1 chk("s1_grant", 32'(s_req_ready), 32'(exp_oh));
            @(negedge clk);                  // EXEC (single cycle)
            chk("s1_fpu_a",   s_fpu_a, a1);
            chk("s1_fpu_b",   s_fpu_b, b1);
            chk("s1_fpu_cmd", 32'(s_fpu_cmd), 32'(c1));
            s_req_valid = 2'b00;
            s_req_a     = ~s_req_a;
            s_req_b     = ~s_req_b;
            s_req_cmd   = ~s_req_cmd;
            @(negedge clk);                  // RESP
            chk("s1_rsp_valid",  32'(s_rsp_valid), 32'(exp_oh));
            chk("s1_result",     s_rsp_result, fpu_model(a1, b1, c1));
            chk("s1_fpu_a_resp", s_fpu_a, a1);
            s_rsp_ready = 2'b11;
            @(negedge clk);                  // IDLE
            s_rsp_ready = 2'b00;
            chk("s1_rsp_clear",  32'(s_rsp_valid), 32'd0);
            chk("s1_fpu_a_idle", s_fpu_a, a1);
            chk("s1_fpu_cmd_idle", 32'(s_fpu_cmd), 32'(c1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
